// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven HH:MM time-set sequencer for the real-time clock
//
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   BTN_MODE, BTN_INC         raw push-buttons (high = pressed)
//   TICK                      2 Hz one-cycle enable (blink, timeout, repeat rate)
//   CUR_HRM..CUR_MINL         live BCD time from the clock counter
//   LOAD                      one-cycle strobe loading LD_* into the clock counter
//   LD_HRM..LD_MINL           BCD edit registers
//   BLINK_HR, BLINK_MIN       blank the field under edit this cycle
//   MODE                      FSM state: RUN=00 SET_HR=01 SET_MIN=10 COMMIT=11
//
// Optional build macro TSET_AUTOREPEAT_EN: holding INC in an edit state
// auto-increments on every TICK once it has been held for REP_TICKS TICKs.
module time_set_ctrl #(
    parameter int DEB_CYCLES    = 16,
    parameter int TIMEOUT_TICKS = 20
`ifdef TSET_AUTOREPEAT_EN
    , parameter int REP_TICKS   = 2
`endif
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_MODE,
    input  logic       BTN_INC,
    input  logic       TICK,
    input  logic [3:0] CUR_HRM,
    input  logic [3:0] CUR_HRL,
    input  logic [3:0] CUR_MINM,
    input  logic [3:0] CUR_MINL,
    output logic       LOAD,
    output logic [3:0] LD_HRM,
    output logic [3:0] LD_HRL,
    output logic [3:0] LD_MINM,
    output logic [3:0] LD_MINL,
    output logic       BLINK_HR,
    output logic       BLINK_MIN,
    output logic [1:0] MODE
);
    typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10, COMMIT = 2'b11} state_t;

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic [1:0] btn;
    logic [1:0] rise;
    assign btn = {BTN_INC, BTN_MODE};

    // Per button: 2-flop synchronizer, then the level only follows the synced
    // input after it has disagreed for DEB_CYCLES consecutive cycles.
    // The press event fires in the same cycle the level rises.
    for (genvar b = 0; b < 2; b++) begin : g_deb
        logic          s1_q, s2_q, lvl_q;
        logic [DW-1:0] cnt_q;
        logic          flip;
        assign flip    = (s2_q != lvl_q) && (cnt_q == DW'(DEB_CYCLES - 1));
        assign rise[b] = flip & s2_q;
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                lvl_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                s1_q <= btn[b];
                s2_q <= s1_q;
                if (s2_q == lvl_q) begin
                    cnt_q <= '0;
                end else if (flip) begin
                    cnt_q <= '0;
                    lvl_q <= s2_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    state_t        state_q;
    logic          load_q, phase_q;
    logic [TW-1:0] tmo_q;
    logic [3:0]    hrm_q, hrl_q, minm_q, minl_q;

    logic edit, expire, mode_ev, inc_ev;
    assign edit    = (state_q == SET_HR) || (state_q == SET_MIN);
    assign expire  = edit && TICK && (tmo_q == TW'(TIMEOUT_TICKS - 1));
    assign mode_ev = rise[0];

`ifdef TSET_AUTOREPEAT_EN
    localparam int HW = $clog2(REP_TICKS + 2);
    logic [HW-1:0] hold_q;
    logic          held, rep;
    assign held   = edit && g_deb[1].lvl_q;
    assign rep    = held && TICK && (hold_q == HW'(REP_TICKS));
    assign inc_ev = rise[1] | rep;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            hold_q <= '0;
        else if (!held)
            hold_q <= '0;
        else if (TICK && hold_q != HW'(REP_TICKS))
            hold_q <= hold_q + 1'b1;
    end
`else
    assign inc_ev = rise[1];
`endif

    // Copy sanitising: an out-of-range field is replaced by 00.
    logic hr_ok, min_ok;
    assign hr_ok  = (CUR_HRM < 4'd2 && CUR_HRL <= 4'd9) || (CUR_HRM == 4'd2 && CUR_HRL <= 4'd3);
    assign min_ok = (CUR_MINM <= 4'd5) && (CUR_MINL <= 4'd9);

    // BCD increments: hours 00..23, minutes 00..59, no carry between fields.
    logic       hr_top;
    logic [3:0] hrm_inc, hrl_inc, minm_inc, minl_inc;
    assign hr_top   = (hrm_q == 4'd2) && (hrl_q == 4'd3);
    assign hrl_inc  = (hr_top || hrl_q == 4'd9) ? 4'd0 : hrl_q + 4'd1;
    assign hrm_inc  = hr_top ? 4'd0 : (hrl_q == 4'd9 ? hrm_q + 4'd1 : hrm_q);
    assign minl_inc = (minl_q == 4'd9) ? 4'd0 : minl_q + 4'd1;
    assign minm_inc = (minl_q != 4'd9) ? minm_q : (minm_q == 4'd5 ? 4'd0 : minm_q + 4'd1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            load_q  <= 1'b0;
            phase_q <= 1'b0;
            tmo_q   <= '0;
            hrm_q   <= 4'd0;
            hrl_q   <= 4'd0;
            minm_q  <= 4'd0;
            minl_q  <= 4'd0;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (mode_ev) begin
                        state_q <= SET_HR;
                        tmo_q   <= '0;
                        phase_q <= 1'b0;
                        hrm_q   <= hr_ok ? CUR_HRM : 4'd0;
                        hrl_q   <= hr_ok ? CUR_HRL : 4'd0;
                        minm_q  <= min_ok ? CUR_MINM : 4'd0;
                        minl_q  <= min_ok ? CUR_MINL : 4'd0;
                    end
                end
                SET_HR, SET_MIN: begin
                    // Expiry beats any press; MODE beats INC.
                    if (expire) begin
                        state_q <= RUN;
                        tmo_q   <= '0;
                        phase_q <= 1'b0;
                    end else if (mode_ev) begin
                        state_q <= (state_q == SET_HR) ? SET_MIN : COMMIT;
                        load_q  <= (state_q == SET_MIN);
                        tmo_q   <= '0;
                        phase_q <= 1'b0;
                    end else if (inc_ev) begin
                        tmo_q   <= '0;
                        phase_q <= 1'b0;
                        if (state_q == SET_HR) begin
                            hrm_q <= hrm_inc;
                            hrl_q <= hrl_inc;
                        end else begin
                            minm_q <= minm_inc;
                            minl_q <= minl_inc;
                        end
                    end else if (TICK) begin
                        tmo_q   <= tmo_q + 1'b1;
                        phase_q <= ~phase_q;
                    end
                end
                default: begin
                    state_q <= RUN;
                    tmo_q   <= '0;
                    phase_q <= 1'b0;
                end
            endcase
        end
    end

    assign LOAD      = load_q;
    assign MODE      = state_q;
    assign LD_HRM    = hrm_q;
    assign LD_HRL    = hrl_q;
    assign LD_MINM   = minm_q;
    assign LD_MINL   = minl_q;
    assign BLINK_HR  = (state_q == SET_HR) & phase_q;
    assign BLINK_MIN = (state_q == SET_MIN) & phase_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;
    logic       CLK = 1'b0, RST = 1'b1, BTN_MODE = 1'b0, BTN_INC = 1'b0, TICK = 1'b0;
    logic [3:0] CUR_HRM = 4'd0, CUR_HRL = 4'd0, CUR_MINM = 4'd0, CUR_MINL = 4'd0;
    logic       LOAD, BLINK_HR, BLINK_MIN;
    logic [3:0] LD_HRM, LD_HRL, LD_MINM, LD_MINL;
    logic [1:0] MODE;
    int total = 0, bad = 0;

    time_set_ctrl dut (
        .CLK(CLK), .RST(RST), .BTN_MODE(BTN_MODE), .BTN_INC(BTN_INC), .TICK(TICK),
        .CUR_HRM(CUR_HRM), .CUR_HRL(CUR_HRL), .CUR_MINM(CUR_MINM), .CUR_MINL(CUR_MINL),
        .LOAD(LOAD), .LD_HRM(LD_HRM), .LD_HRL(LD_HRL), .LD_MINM(LD_MINM), .LD_MINL(LD_MINL),
        .BLINK_HR(BLINK_HR), .BLINK_MIN(BLINK_MIN), .MODE(MODE)
    );

    always #5 CLK = ~CLK;

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input logic m, input logic i);
        @(negedge CLK);
        BTN_MODE = m;
        BTN_INC  = i;
        cyc(20);
        BTN_MODE = 1'b0;
        BTN_INC  = 1'b0;
        cyc(20);
    endtask

    task automatic tick1;
        @(negedge CLK);
        TICK = 1'b1;
        @(negedge CLK);
        TICK = 1'b0;
    endtask

    task automatic set_cur(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        CUR_HRM = a; CUR_HRL = b; CUR_MINM = c; CUR_MINL = d;
    endtask

    task automatic test_reset;
        cyc(3);
        total++; if (MODE !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d want=0", MODE); end
        total++; if (LOAD !== 1'b0) begin bad++; $display("FAIL reset_load got=%b want=0", LOAD); end
        total++; if ({BLINK_HR, BLINK_MIN} !== 2'b00) begin bad++; $display("FAIL reset_blink got=%b want=00", {BLINK_HR, BLINK_MIN}); end
        total++; if ({LD_HRM, LD_HRL, LD_MINM, LD_MINL} !== 16'h0000) begin bad++; $display("FAIL reset_ld got=%h want=0000", {LD_HRM, LD_HRL, LD_MINM, LD_MINL}); end
        RST = 1'b0;
        cyc(3);
    endtask

    task automatic test_debounce;
        int n;
        set_cur(4'd2, 4'd3, 4'd5, 4'd9);
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            BTN_MODE = 1'b1; cyc(5);
            BTN_MODE = 1'b0; cyc(5);
        end
        cyc(20);
        total++; if (MODE !== 2'd0) begin bad++; $display("FAIL bounce_no_event got=%0d want=0", MODE); end
        BTN_MODE = 1'b1;
        n = 0;
        while (MODE !== 2'd1 && n < 40) begin @(negedge CLK); n++; end
        total++; if (n < 17 || n > 18) begin bad++; $display("FAIL deb_latency got=%0d want=17..18", n); end
        cyc(30);
        BTN_MODE = 1'b0;
        cyc(25);
        total++; if (MODE !== 2'd1) begin bad++; $display("FAIL deb_single_event got=%0d want=1", MODE); end
        total++; if ({LD_HRM, LD_HRL, LD_MINM, LD_MINL} !== 16'h2359) begin bad++; $display("FAIL copy_2359 got=%h want=2359", {LD_HRM, LD_HRL, LD_MINM, LD_MINL}); end
    endtask

    task automatic test_commit;
        int loads;
        logic [15:0] ld_at;
        logic [1:0]  mode_at;
        press(1'b0, 1'b1);
        total++; if ({LD_HRM, LD_HRL, LD_MINM, LD_MINL} !== 16'h0059) begin bad++; $display("FAIL hr_wrap_23 got=%h want=0059", {LD_HRM, LD_HRL, LD_MINM, LD_MINL}); end
        press(1'b1, 1'b0);
        total++; if (MODE !== 2'd2) begin bad++; $display("FAIL to_set_min got=%0d want=2", MODE); end
        loads = 0; ld_at = 16'hffff; mode_at = 2'd0;
        @(negedge CLK);
        BTN_MODE = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (LOAD === 1'b1) begin
                loads++;
                ld_at   = {LD_HRM, LD_HRL, LD_MINM, LD_MINL};
                mode_at = MODE;
            end
        end
        BTN_MODE = 1'b0;
        cyc(20);
        total++; if (loads != 1) begin bad++; $display("FAIL load_count got=%0d want=1", loads); end
        total++; if (ld_at !== 16'h0059) begin bad++; $display("FAIL load_value got=%h want=0059", ld_at); end
        total++; if (mode_at !== 2'd3) begin bad++; $display("FAIL load_mode got=%0d want=3", mode_at); end
        total++; if (MODE !== 2'd0) begin bad++; $display("FAIL after_commit got=%0d want=0", MODE); end
    endtask

    task automatic test_wrap;
        set_cur(4'd1, 4'd2, 4'd5, 4'd8);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        total++; if ({LD_MINM, LD_MINL} !== 8'h59) begin bad++; $display("FAIL min_58_inc got=%h want=59", {LD_MINM, LD_MINL}); end
        press(1'b0, 1'b1);
        total++; if ({LD_HRM, LD_HRL, LD_MINM, LD_MINL} !== 16'h1200) begin bad++; $display("FAIL min_wrap got=%h want=1200", {LD_HRM, LD_HRL, LD_MINM, LD_MINL}); end
        press(1'b1, 1'b0);
        cyc(2);
        total++; if (MODE !== 2'd0) begin bad++; $display("FAIL wrap_commit got=%0d want=0", MODE); end
        set_cur(4'd0, 4'd9, 4'd3, 4'd0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        total++; if ({LD_HRM, LD_HRL} !== 8'h10) begin bad++; $display("FAIL hr_09_carry got=%h want=10", {LD_HRM, LD_HRL}); end
    endtask

    task automatic test_simultaneous;
        press(1'b1, 1'b1);
        total++; if (MODE !== 2'd2) begin bad++; $display("FAIL simul_mode got=%0d want=2", MODE); end
        total++; if ({LD_HRM, LD_HRL, LD_MINM, LD_MINL} !== 16'h1030) begin bad++; $display("FAIL simul_value got=%h want=1030", {LD_HRM, LD_HRL, LD_MINM, LD_MINL}); end
        press(1'b1, 1'b0);
        cyc(2);
        total++; if (MODE !== 2'd0) begin bad++; $display("FAIL simul_commit got=%0d want=0", MODE); end
    endtask

    task automatic test_timeout;
        int loads, toggles;
        logic prev;
        set_cur(4'd0, 4'd7, 4'd4, 4'd5);
        press(1'b1, 1'b0);
        total++; if ({MODE, BLINK_HR} !== 3'b010) begin bad++; $display("FAIL tmo_entry got=%b want=010", {MODE, BLINK_HR}); end
        loads = 0; toggles = 0; prev = BLINK_HR;
        for (int k = 0; k < 20; k++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge CLK);
                TICK = (c == 0);
                if (LOAD === 1'b1) loads++;
            end
            if (k < 19) begin
                if (BLINK_HR !== prev) toggles++;
                prev = BLINK_HR;
            end
            if (k == 18) begin
                total++; if (MODE !== 2'd1) begin bad++; $display("FAIL tmo_early got=%0d want=1", MODE); end
            end
        end
        total++; if (MODE !== 2'd0) begin bad++; $display("FAIL tmo_mode got=%0d want=0", MODE); end
        total++; if (BLINK_HR !== 1'b0) begin bad++; $display("FAIL tmo_blink got=%b want=0", BLINK_HR); end
        total++; if (toggles != 19) begin bad++; $display("FAIL tmo_toggles got=%0d want=19", toggles); end
        total++; if (loads != 0) begin bad++; $display("FAIL tmo_load got=%0d want=0", loads); end
    endtask

    task automatic test_reset_mid_edit;
        int loads;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        total++; if ({LD_HRM, LD_HRL} !== 8'h08) begin bad++; $display("FAIL mid_inc got=%h want=08", {LD_HRM, LD_HRL}); end
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        total++; if ({MODE, LOAD} !== 3'b000) begin bad++; $display("FAIL mid_rst_state got=%b want=000", {MODE, LOAD}); end
        total++; if ({LD_HRM, LD_HRL, LD_MINM, LD_MINL} !== 16'h0000) begin bad++; $display("FAIL mid_rst_ld got=%h want=0000", {LD_HRM, LD_HRL, LD_MINM, LD_MINL}); end
        cyc(2);
        RST = 1'b0;
        loads = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (LOAD === 1'b1) loads++;
        end
        total++; if (loads != 0 || MODE !== 2'd0) begin bad++; $display("FAIL mid_rst_after got=%0d/%0d want=0/0", loads, MODE); end
    endtask

`ifdef TSET_AUTOREPEAT_EN
    task automatic test_autorepeat;
        set_cur(4'd0, 4'd0, 4'd1, 4'd0);
        press(1'b1, 1'b0);
        @(negedge CLK);
        BTN_INC = 1'b1;
        cyc(25);
        total++; if ({LD_HRM, LD_HRL} !== 8'h01) begin bad++; $display("FAIL rep_edge got=%h want=01", {LD_HRM, LD_HRL}); end
        for (int k = 0; k < 6; k++) begin
            tick1;
            cyc(2);
        end
        total++; if ({LD_HRM, LD_HRL} !== 8'h05) begin bad++; $display("FAIL rep_value got=%h want=05", {LD_HRM, LD_HRL}); end
        total++; if (MODE !== 2'd1) begin bad++; $display("FAIL rep_mode got=%0d want=1", MODE); end
        BTN_INC = 1'b0;
        cyc(25);
        total++; if ({LD_HRM, LD_HRL} !== 8'h05) begin bad++; $display("FAIL rep_release got=%h want=05", {LD_HRM, LD_HRL}); end
    endtask
`endif

    initial begin
        test_reset;
        test_debounce;
        test_commit;
        test_wrap;
        test_simultaneous;
        test_timeout;
        test_reset_mid_edit;
`ifdef TSET_AUTOREPEAT_EN
        test_autorepeat;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Button-driven controller that sequences the real-time clock's time-set operation. Debounces two raw push-buttons and steps an FSM through hour and minute edit modes. Holds edit copies of the HH:MM BCD digits and issues a one-cycle LOAD strobe, with the digits, into the clock counter chain. Drives per-field blink enables to the seven-segment scan logic so the field being edited flashes.

Parameters:
DEB_CYCLES, 16, consecutive stable CLK cycles required before a debounced button level changes
TIMEOUT_TICKS, 20, TICK pulses with no button press in an edit state before the edit is abandoned
REP_TICKS, 2, TICK pulses INC must be held before auto-repeat starts (used only with the optional feature)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
BTN_MODE  in  1  raw, asynchronous MODE push-button (high = pressed)
BTN_INC  in  1  raw, asynchronous INC push-button (high = pressed)
TICK  in  1  one-CLK-cycle enable pulse, 2 Hz; sets blink, timeout and repeat rate
CUR_HRM, CUR_HRL, CUR_MINM, CUR_MINL  in  4 each  live BCD time from the clock counter
LOAD  out  1  one-cycle strobe; the clock counter loads LD_* and clears seconds to 00
LD_HRM, LD_HRL, LD_MINM, LD_MINL  out  4 each  BCD edit registers, valid whenever LOAD=1
BLINK_HR  out  1  high = blank the hour digits this cycle
BLINK_MIN  out  1  high = blank the minute digits this cycle
MODE  out  2  current FSM state encoding

Behaviour:
- Reset (async, RST=1): state RUN, LOAD=0, BLINK_*=0, LD_*=0, debounce/sync/timeout/blink registers cleared.
- Button front end: 2-flop synchronizer per button, then a counter.
  - Debounced level flips only after the synced input differs from it for DEB_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - A press event is a 1-cycle pulse on a debounced 0->1 transition. A release generates no event.
- FSM (MODE encoding): RUN=00, SET_HR=01, SET_MIN=10, COMMIT=11.
  - RUN: INC ignored. On a MODE press, copy CUR_* into the edit registers and enter SET_HR.
    - Copy sanitising: an hour >23 or any digit >9 loads 00 for that field.
  - SET_HR: INC press increments the hour in BCD, 00..23. LSD 9->0 carries; 23 wraps to 00. MODE press enters SET_MIN.
  - SET_MIN: INC press increments the minute in BCD, 00..59. 59 wraps to 00 with no carry into hours. MODE press enters COMMIT.
  - COMMIT: lasts exactly 1 cycle with LOAD=1, then RUN. Latency from the debounced MODE press to LOAD is 1 cycle.
- Simultaneous MODE and INC press events in the same cycle: MODE wins and the INC event is discarded.
- Timeout:
  - The counter clears on every press event and on every state entry.
  - It advances on each TICK in SET_HR or SET_MIN.
  - On reaching TIMEOUT_TICKS, the FSM returns to RUN with no LOAD and the edit is discarded.
  - A press in the same cycle as expiry is discarded.
- Blink:
  - The phase bit toggles on each TICK in an edit state and is forced to 0 (digits visible) on state entry and after every INC press.
  - BLINK_HR = (state==SET_HR) & phase. BLINK_MIN = (state==SET_MIN) & phase. Both are 0 in RUN and COMMIT.
- LD_* always reflect the edit registers. They change only on copy or increment, never while LOAD=1.
- RST asserted mid-edit: the edit is lost, no LOAD occurs, and the clock keeps its current value.

Optional Feature:
Macro TSET_AUTOREPEAT_EN.
- Defined: in SET_HR or SET_MIN, while the debounced INC level stays high, a hold counter counts TICKs. Once it reaches REP_TICKS, every further TICK produces an increment, identical to a press event, and resets the timeout. Releasing INC clears the hold counter.
- Undefined: only debounced rising edges increment; REP_TICKS is unused and no hold logic is synthesised.

Test Plan:
- Bounce BTN_MODE 3 times with a 5-cycle gap, then hold stable, DEB_CYCLES=16 -> exactly one press event; MODE goes 00->01 once, 17-18 cycles after the final edge.
- CUR=23:59, MODE press, INC x1, MODE, MODE -> LD_*=0,0,5,9 with LOAD high for exactly 1 cycle, then MODE=00.
- In SET_MIN from 58, INC x2 -> minutes 00, hours unchanged; in SET_HR from 09, INC -> hour 10.
- MODE and INC press on the same cycle in SET_HR -> state SET_MIN, hour value unchanged.
- Enter SET_HR, no presses for 20 TICKs -> MODE=00, LOAD never asserted, BLINK_HR toggled 19 times then 0.
- With TSET_AUTOREPEAT_EN defined and REP_TICKS=2, hold INC in SET_HR for 6 TICKs from hour 00 -> hour 05 (1 from the edge, 4 from repeat); no timeout occurs.
